byte_or_serial_tx: RTL and testbench
====================================

// Module: byte_or_serial_tx
// PURPOSE
//  Bit-serial transmit end of the byte-OR datapath: accepts two operand words via valid/ready,
//  computes their bitwise OR one bit per clock, shifts each result bit out LSB-first, and
//  presents the reassembled word at frame end. Feeds narrow serial links with OR'd byte streams.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2); bit counter is $clog2(WIDTH) bits wide
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  B_in1      in   WIDTH  operand 1, sampled on accept
//  B_in2      in   WIDTH  operand 2, sampled on accept
//  in_valid   in   1      operands present
//  in_ready   out  1      block can accept (high only in IDLE)
//  bit_out    out  1      current serial result bit
//  bit_valid  out  1      bit_out carries a frame bit this cycle
//  frame_end  out  1      one-cycle pulse in the cycle after the last frame bit
//  B_out      out  WIDTH  reassembled OR result, updated with frame_end, held until next frame_end
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, bit_out=0, bit_valid=0,
//    frame_end=0, B_out=0, shift regs and counter = 0.
//  - Accept: in_valid && in_ready on edge N -> B_in1/B_in2 latched into shift regs, state=SHIFT.
//  - SHIFT: bit_out = sh1[0] | sh2[0], bit_valid=1; each cycle both regs shift right by 1,
//    result bit shifts into acc from the MSB side; counter increments. First bit is valid in
//    cycle N+1; bit k (0..WIDTH-1) in cycle N+1+k.
//  - After bit WIDTH-1 (counter==WIDTH-1): -> DONE (or PARITY if enabled).
//  - DONE: one cycle; frame_end=1, B_out<=acc (== B_in1|B_in2 as accepted), bit_valid=0,
//    in_ready=0; next state IDLE. Throughput: one word per WIDTH+2 cycles.
//  - in_valid while not IDLE is ignored (no accept); operands changing after accept have no effect.
//  - bit_out=0 whenever bit_valid=0.
//  - Reset mid-frame aborts: outputs return to reset values immediately, B_out cleared, no frame_end.
//  - Counter never wraps inside a frame; cleared on accept.
// CONFIGURATION
//  BYTE_OR_PARITY_EN defined: extra PARITY state after bit WIDTH-1; bit_out = ^acc (even parity of
//    the result word), bit_valid=1; frame = WIDTH+1 bits; DONE follows; throughput WIDTH+3 cycles.
//  Not defined: no PARITY state; frame = WIDTH bits exactly.
// STRUCTURE
//  Shared package byte_or_pkg: state enum (IDLE, SHIFT, PARITY, DONE) and default width constant 8;
//    PARITY encoding reserved even when the macro is off.
//  Single FSM + datapath module; no sub-module needed (shift/accumulate is a few registers).
// TESTING
//  1. Reset then B_in1=8'h0F, B_in2=8'hA0, in_valid 1 cycle -> bits 1,1,1,1,0,1,0,1 in cycles N+1..N+8,
//     frame_end at N+9, B_out=8'hAF.
//  2. B_in1=8'h00, B_in2=8'h00 -> 8 zero bits with bit_valid=1, B_out=8'h00; with parity: 9th bit 0.
//  3. B_in1=8'h80, B_in2=8'h01 with BYTE_OR_PARITY_EN -> bits 1,0,0,0,0,0,0,1 then parity 0,
//     B_out=8'h81; same operands 8'h80/8'h00 -> parity bit 1.
//  4. in_valid held high continuously with changing operands 8'h11/8'h22 then 8'h44/8'h88 -> two
//     frames, B_out=8'h33 then 8'hCC, in_ready low during each frame, second accept right after DONE.
//  5. rst asserted at bit 4 of frame with 8'hFF/8'h00 -> bit_valid, in_ready, B_out return to reset
//     values same cycle; no frame_end; next frame 8'h01/8'h02 yields B_out=8'h03.
//  6. WIDTH=4, 4'h5/4'hA -> four 1 bits, B_out=4'hF, frame_end 5 cycles after accept.

Source files
------------

// File: rtl/byte_or_pkg.sv
// Shared definitions for the byte-OR serial datapath.
// Contents: default operand width and the FSM state encoding. PARITY keeps its
// encoding even in builds where the parity state is never entered.
package byte_or_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/byte_or_serial_tx.sv
// Bit-serial transmitter for the bitwise OR of two operand words.
// Accepts B_in1/B_in2 via in_valid/in_ready, shifts the OR result out LSB-first
// on bit_out/bit_valid, then pulses frame_end while B_out shows the full result.
// Optional feature: define BYTE_OR_PARITY_EN to append an even-parity bit.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   B_in1, B_in2       operands, sampled on accept
//   in_valid/in_ready  operand handshake (ready only in IDLE)
//   bit_out/bit_valid  serial result bit and its qualifier
//   frame_end          one-cycle pulse after the last frame bit
//   B_out              reassembled result, held until the next frame_end
module byte_or_serial_tx
   import byte_or_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] B_in1,
   input  logic [WIDTH-1:0] B_in2,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_end,
   output logic [WIDTH-1:0] B_out
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh1, sh2, acc, acc_nxt;
   logic [CW-1:0]    cnt;
   logic             cur_bit;

   // Current result bit and the accumulator after absorbing it from the MSB side
   always_comb begin
      cur_bit = sh1[0] | sh2[0];
      acc_nxt = {cur_bit, acc[WIDTH-1:1]};
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = SHIFT;
         SHIFT: begin
            if (cnt == LAST) begin
`ifdef BYTE_OR_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = DONE;
`endif
            end
         end
         PARITY:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      in_ready  = 1'b0;
      bit_valid = 1'b0;
      bit_out   = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE:   in_ready = 1'b1;
         SHIFT: begin
            bit_valid = 1'b1;
            bit_out   = cur_bit;
         end
         PARITY: begin
            bit_valid = 1'b1;
            bit_out   = ^acc;
         end
         DONE:   frame_end = 1'b1;
         default: ;
      endcase
   end

   // Operand shift registers, accumulator, bit counter and result register.
   // B_out is loaded on the edge entering DONE so it changes together with frame_end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh1   <= '0;
         sh2   <= '0;
         acc   <= '0;
         cnt   <= '0;
         B_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh1 <= B_in1;
                  sh2 <= B_in2;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            SHIFT: begin
               sh1 <= sh1 >> 1;
               sh2 <= sh2 >> 1;
               acc <= acc_nxt;
               // Saturate on the last bit so the counter never wraps inside a frame
               if (cnt != LAST) cnt <= cnt + CW'(1);
`ifndef BYTE_OR_PARITY_EN
               if (cnt == LAST) B_out <= acc_nxt;
`endif
            end
            PARITY:  B_out <= acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_or_serial_tx.sv
// Self-checking bench for byte_or_serial_tx: a queue-based frame model checks
// every cycle of an 8-bit instance; directed frames pin literal results, and a
// 4-bit instance checks the narrow-width case.
module tb_byte_or_serial_tx;

`ifdef BYTE_OR_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   typedef struct packed {
      logic       bv;
      logic       bo;
      logic       fe;
      logic       rdy;
      logic [7:0] bout;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] b1 = '0, b2 = '0;
   logic       in_valid = 1'b0;
   logic       in_ready, bit_out, bit_valid, frame_end;
   logic [7:0] b_out;

   logic [3:0] a4 = '0, c4 = '0;
   logic       v4 = 1'b0;
   logic       rdy4, bo4, bv4, fe4;
   logic [3:0] b_out4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   byte_or_serial_tx #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .B_in1(b1), .B_in2(b2), .in_valid(in_valid),
      .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
      .frame_end(frame_end), .B_out(b_out));

   byte_or_serial_tx #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .B_in1(a4), .B_in2(c4), .in_valid(v4),
      .in_ready(rdy4), .bit_out(bo4), .bit_valid(bv4),
      .frame_end(fe4), .B_out(b_out4));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Frame model: on accept, queue the whole expected frame cycle by cycle
   exp_t q[$];
   exp_t cur;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         cur <= '{bv: 1'b0, bo: 1'b0, fe: 1'b0, rdy: 1'b1, bout: 8'h00};
      end else if (q.size() == 0 && cur.rdy && in_valid) begin
         logic [7:0] r;
         r = b1 | b2;
         for (int k = 0; k < 8; k++)
            q.push_back('{bv: 1'b1, bo: r[k], fe: 1'b0, rdy: 1'b0, bout: cur.bout});
         if (PB == 1)
            q.push_back('{bv: 1'b1, bo: ^r, fe: 1'b0, rdy: 1'b0, bout: cur.bout});
         q.push_back('{bv: 1'b0, bo: 1'b0, fe: 1'b1, rdy: 1'b0, bout: r});
         cur <= q.pop_front();
      end else if (q.size() != 0) begin
         cur <= q.pop_front();
      end else begin
         cur <= '{bv: 1'b0, bo: 1'b0, fe: 1'b0, rdy: 1'b1, bout: cur.bout};
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("m_bit_valid", 32'(bit_valid), 32'(cur.bv));
         chk("m_bit_out",   32'(bit_out),   32'(cur.bo));
         chk("m_frame_end", 32'(frame_end), 32'(cur.fe));
         chk("m_in_ready",  32'(in_ready),  32'(cur.rdy));
         chk("m_b_out",     32'(b_out),     32'(cur.bout));
      end
   end

   // Collect serial bits of each frame for the directed literal checks
   logic [15:0] bits, last_bits;
   int          nbits, last_cnt;
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         bits  = '0;
         nbits = 0;
      end else begin
         if (bit_valid) begin
            bits[nbits[3:0]] = bit_out;
            nbits++;
         end
         if (frame_end) begin
            last_bits = bits;
            last_cnt  = nbits;
            bits      = '0;
            nbits     = 0;
         end
      end
   end

   // Bounded wait until the DUT is ready
   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", 32'd1, 32'd0);
   endtask

   // Bounded wait for frame_end; lat counts cycles since the accept edge
   task automatic wait_fe(inout int lat);
      while (!frame_end && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!frame_end) chk("frame_end_timeout", 32'd1, 32'd0);
   endtask

   // One frame with in_valid pulsed for a single accept; returns accept-to-frame_end latency
   task automatic run_frame(input logic [7:0] x, input logic [7:0] y, output int lat);
      @(negedge clk);
      wait_ready();
      in_valid = 1'b1;
      b1 = x;
      b2 = y;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      wait_fe(lat);
      #1;
   endtask

   initial begin
      int lat;
      int ones;
      #12;
      // Reset values
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_bit_valid", 32'(bit_valid), 32'd0);
      chk("rst_bit_out",   32'(bit_out),   32'd0);
      chk("rst_frame_end", 32'(frame_end), 32'd0);
      chk("rst_b_out",     32'(b_out),     32'd0);
      #10 rst = 1'b0;

      // 0F | A0 -> AF, bits LSB-first 1,1,1,1,0,1,0,1
      run_frame(8'h0F, 8'hA0, lat);
      chk("t1_latency", 32'(lat), 32'(9 + PB));
      chk("t1_bits", 32'(last_bits[7:0]), 32'hAF);
      chk("t1_count", 32'(last_cnt), 32'(8 + PB));
      chk("t1_b_out", 32'(b_out), 32'hAF);
      if (PB == 1) chk("t1_parity", 32'(last_bits[8]), 32'd0);

      // All-zero operands still produce a full frame of valid zero bits
      run_frame(8'h00, 8'h00, lat);
      chk("t2_count", 32'(last_cnt), 32'(8 + PB));
      chk("t2_bits", 32'(last_bits), 32'h0);
      chk("t2_b_out", 32'(b_out), 32'h00);

      // 80 | 01 -> 81 (even parity 0); 80 | 00 -> 80 (parity 1)
      run_frame(8'h80, 8'h01, lat);
      chk("t3a_bits", 32'(last_bits[7:0]), 32'h81);
      chk("t3a_b_out", 32'(b_out), 32'h81);
      if (PB == 1) chk("t3a_parity", 32'(last_bits[8]), 32'd0);
      run_frame(8'h80, 8'h00, lat);
      chk("t3b_b_out", 32'(b_out), 32'h80);
      if (PB == 1) chk("t3b_parity", 32'(last_bits[8]), 32'd1);

      // in_valid held high; operands changed mid-frame must not leak into frame 1
      @(negedge clk);
      wait_ready();
      in_valid = 1'b1;
      b1 = 8'h11;
      b2 = 8'h22;
      @(negedge clk);
      chk("t4_ready_low", 32'(in_ready), 32'd0);
      b1 = 8'h44;
      b2 = 8'h88;
      lat = 1;
      wait_fe(lat);
      #1;
      chk("t4a_b_out", 32'(b_out), 32'h33);
      @(negedge clk);
      chk("t4_ready_gap", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("t4_second_accept", 32'(in_ready), 32'd0);
      lat = 1;
      wait_fe(lat);
      in_valid = 1'b0;
      #1;
      chk("t4b_b_out", 32'(b_out), 32'hCC);
      chk("t4b_latency", 32'(lat), 32'(9 + PB));

      // Reset in the middle of a frame, at bit 4
      @(negedge clk);
      wait_ready();
      in_valid = 1'b1;
      b1 = 8'hFF;
      b2 = 8'h00;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_pre_valid", 32'(bit_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_bit_valid", 32'(bit_valid), 32'd0);
      chk("t5_bit_out",   32'(bit_out),   32'd0);
      chk("t5_in_ready",  32'(in_ready),  32'd1);
      chk("t5_b_out",     32'(b_out),     32'd0);
      chk("t5_frame_end", 32'(frame_end), 32'd0);
      #10 rst = 1'b0;
      run_frame(8'h01, 8'h02, lat);
      chk("t5_next_b_out", 32'(b_out), 32'h03);

      // Narrow instance: 5 | A -> F, four one bits
      @(negedge clk);
      v4 = 1'b1;
      a4 = 4'h5;
      c4 = 4'hA;
      @(negedge clk);
      v4 = 1'b0;
      lat = 1;
      ones = 0;
      while (!fe4 && lat < 40) begin
         if (bv4 && bo4) ones++;
         @(negedge clk);
         lat++;
      end
      chk("t6_latency", 32'(lat), 32'(5 + PB));
      chk("t6_ones", 32'(ones), 32'd4);
      chk("t6_b_out", 32'(b_out4), 32'hF);

      // Random operands and in_valid activity, checked by the model every cycle
      repeat (1500) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 3) != 0);
         b1 = 8'($urandom);
         b2 = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
